// File: rtl/bit_sample_count_rx.sv
// Oversampling sample/bit counter for the UART receive path; strobes RControl at the mid-bit sample.
// Latency: RControl/frame_done are registered and rise one clk after the edge that sees SAMPLE_POINT.
// Backpressure: none; enable=0 synchronously clears the counters and aborts the frame.
//
// Ports:
//   clk        - receive sample clock, rising-edge active
//   rst        - asynchronous active-low reset
//   enable     - count enable, high while a frame is being received
//   RControl   - one-cycle strobe telling the shift register to capture the line
//   sample_cnt - current sample index within the bit
//   bit_cnt    - current bit index within the frame
//   frame_done - one-cycle strobe coincident with RControl for the last bit of the frame
module bit_sample_count_rx #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int SAMPLE_POINT    = 7,
  parameter int BITS_PER_FRAME  = 10,
  localparam int SW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1,
  localparam int BW = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          RControl,
  output logic [SW-1:0] sample_cnt,
  output logic [BW-1:0] bit_cnt,
  output logic          frame_done
);

  localparam logic [SW-1:0] SAMPLE_LAST    = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [SW-1:0] SAMPLE_POINT_C = SW'(SAMPLE_POINT);
  localparam logic [BW-1:0] BIT_LAST       = BW'(BITS_PER_FRAME - 1);

  logic [SW-1:0] sample_cnt_q, sample_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          rcontrol_q, rcontrol_d;
  logic          frame_done_q, frame_done_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    rcontrol_d   = 1'b0;
    frame_done_d = 1'b0;
    if (!enable) begin
      // Dropping enable aborts the frame; the next frame starts at sample 0, bit 0.
      sample_cnt_d = '0;
      bit_cnt_d    = '0;
    end else begin
      if (sample_cnt_q == SAMPLE_LAST) begin
        sample_cnt_d = '0;
        bit_cnt_d    = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
      end else begin
        sample_cnt_d = sample_cnt_q + SW'(1);
      end
      // Strobe is decided from the pre-increment count, so it is visible
      // while sample_cnt == SAMPLE_POINT+1 and bit_cnt still names the bit.
      if (sample_cnt_q == SAMPLE_POINT_C) begin
        rcontrol_d   = 1'b1;
        frame_done_d = (bit_cnt_q == BIT_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      rcontrol_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      rcontrol_q   <= rcontrol_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign RControl   = rcontrol_q;
  assign sample_cnt = sample_cnt_q;
  assign bit_cnt    = bit_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bit_sample_count_rx.sv
module tb_bit_sample_count_rx;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       RControl;
  logic [3:0] sample_cnt;
  logic [3:0] bit_cnt;
  logic       frame_done;

  int n_tests;
  int n_fail;
  int k;  // enabled edges since counting started

  bit_sample_count_rx #(
    .SAMPLES_PER_BIT(16),
    .SAMPLE_POINT   (7),
    .BITS_PER_FRAME (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .RControl  (RControl),
    .sample_cnt(sample_cnt),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    n_tests++;
    if (RControl !== 1'b0) begin
      n_fail++; $display("FAIL reset_rcontrol: got %b want 0", RControl);
    end
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
    end
    n_tests++;
    if (sample_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_sample_cnt: got %0d want 0", sample_cnt);
    end
    n_tests++;
    if (bit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt);
    end
  endtask

  // Edges 1..9 after release: strobe only after edge 8.
  task automatic test_first_strobe();
    logic       exp_rc;
    logic [3:0] exp_s;
    rst    = 1'b1;
    enable = 1'b1;
    k      = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      k++;
      exp_rc = (k == 8);
      exp_s  = 4'(k);
      n_tests++;
      if (RControl !== exp_rc) begin
        n_fail++; $display("FAIL first_strobe_rc edge %0d: got %b want %b", k, RControl, exp_rc);
      end
      n_tests++;
      if (sample_cnt !== exp_s) begin
        n_fail++; $display("FAIL first_strobe_sample edge %0d: got %0d want %0d", k, sample_cnt, exp_s);
      end
    end
  endtask

  // Edges 10..40: strobes after 24 and 40, bit_cnt steps after 16 and 32.
  task automatic test_periodicity();
    logic       exp_rc;
    logic [3:0] exp_b;
    for (int i = 10; i <= 40; i++) begin
      tick();
      k++;
      exp_rc = (k == 24) || (k == 40);
      exp_b  = (k < 16) ? 4'd0 : (k < 32) ? 4'd1 : 4'd2;
      n_tests++;
      if (RControl !== exp_rc) begin
        n_fail++; $display("FAIL period_rc edge %0d: got %b want %b", k, RControl, exp_rc);
      end
      n_tests++;
      if (bit_cnt !== exp_b) begin
        n_fail++; $display("FAIL period_bit edge %0d: got %0d want %0d", k, bit_cnt, exp_b);
      end
      n_tests++;
      if (frame_done !== 1'b0) begin
        n_fail++; $display("FAIL period_fd edge %0d: got %b want 0", k, frame_done);
      end
    end
  endtask

  // Edges 41..170: frame_done only with the 10th strobe (edge 152),
  // bit_cnt wraps to 0 at edge 160, next strobe at 168 without frame_done.
  task automatic test_frame_end();
    logic       exp_rc;
    logic       exp_fd;
    logic [3:0] exp_b;
    for (int i = 41; i <= 170; i++) begin
      tick();
      k++;
      exp_rc = (k % 16 == 8);
      exp_fd = (k == 152);
      exp_b  = 4'((k / 16) % 10);
      n_tests++;
      if (RControl !== exp_rc) begin
        n_fail++; $display("FAIL frame_rc edge %0d: got %b want %b", k, RControl, exp_rc);
      end
      n_tests++;
      if (frame_done !== exp_fd) begin
        n_fail++; $display("FAIL frame_fd edge %0d: got %b want %b", k, frame_done, exp_fd);
      end
      n_tests++;
      if (bit_cnt !== exp_b) begin
        n_fail++; $display("FAIL frame_bit edge %0d: got %0d want %0d", k, bit_cnt, exp_b);
      end
    end
    n_tests++;
    if (sample_cnt !== 4'd10) begin
      n_fail++; $display("FAIL frame_sample edge 170: got %0d want 10", sample_cnt);
    end
  endtask

  // Run to edge 213 (sample 5, bit 3), drop enable one cycle, then re-enable.
  // Ends after the 8th re-enabled edge with RControl expected high.
  task automatic test_abort();
    logic exp_rc;
    while (k < 213) begin
      tick();
      k++;
    end
    n_tests++;
    if (sample_cnt !== 4'd5 || bit_cnt !== 4'd3) begin
      n_fail++; $display("FAIL abort_pre: got s=%0d b=%0d want s=5 b=3", sample_cnt, bit_cnt);
    end
    enable = 1'b0;
    tick();
    n_tests++;
    if (sample_cnt !== 4'd0) begin
      n_fail++; $display("FAIL abort_sample: got %0d want 0", sample_cnt);
    end
    n_tests++;
    if (bit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL abort_bit: got %0d want 0", bit_cnt);
    end
    n_tests++;
    if (RControl !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_strobes: got rc=%b fd=%b want 0 0", RControl, frame_done);
    end
    enable = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp_rc = (j == 8);
      n_tests++;
      if (RControl !== exp_rc) begin
        n_fail++; $display("FAIL abort_reenable_rc edge %0d: got %b want %b", j, RControl, exp_rc);
      end
      n_tests++;
      if (sample_cnt !== 4'(j)) begin
        n_fail++; $display("FAIL abort_reenable_sample edge %0d: got %0d want %0d", j, sample_cnt, j);
      end
    end
  endtask

  // Entered with RControl high; reset between edges must clear at once.
  task automatic test_reset_mid_frame();
    logic exp_rc;
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (RControl !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_rc: got %b want 0", RControl);
    end
    n_tests++;
    if (sample_cnt !== 4'd0 || bit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL async_rst_cnt: got s=%0d b=%0d want 0 0", sample_cnt, bit_cnt);
    end
    tick();
    n_tests++;
    if (sample_cnt !== 4'd0 || RControl !== 1'b0) begin
      n_fail++; $display("FAIL rst_hold: got s=%0d rc=%b want 0 0", sample_cnt, RControl);
    end
    rst = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      exp_rc = (j == 8);
      n_tests++;
      if (RControl !== exp_rc) begin
        n_fail++; $display("FAIL rst_restart_rc edge %0d: got %b want %b", j, RControl, exp_rc);
      end
      n_tests++;
      if (sample_cnt !== 4'(j) || bit_cnt !== 4'd0) begin
        n_fail++; $display("FAIL rst_restart_cnt edge %0d: got s=%0d b=%0d want s=%0d b=0", j, sample_cnt, bit_cnt, j);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    k       = 0;
    rst     = 1'b0;
    enable  = 1'b0;
    test_reset();
    test_first_strobe();
    test_periodicity();
    test_frame_end();
    test_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_sample_count_rx.md
Name: bit_sample_count_rx

Overview:
Oversampling sample/bit counter for the UART receive path. While enabled, it counts receive-clock samples within each bit period. It issues a one-cycle RControl strobe at the mid-bit sample point, which tells the receive shift register to capture the serial line. It also tracks the bit index within the frame and flags the final bit's sample.

Parameters:
SAMPLES_PER_BIT, 16, clock samples per serial bit (>=2)
SAMPLE_POINT, 7, sample index (0-based) at which a bit is captured; must be < SAMPLES_PER_BIT
BITS_PER_FRAME, 10, bits per frame (start + 8 data + stop)

Ports:
clk  input  1  receive sample clock, rising-edge active
rst  input  1  asynchronous active-low reset
enable  input  1  count enable; high while a frame is being received
RControl  output  1  one-cycle strobe: shift register captures the line
sample_cnt  output  clog2(SAMPLES_PER_BIT)  current sample index within the bit
bit_cnt  output  clog2(BITS_PER_FRAME)  current bit index within the frame
frame_done  output  1  one-cycle strobe coincident with RControl for the last bit

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst). All state is updated on the clk rising edge.
- Reset (rst=0, asynchronous, independent of clk):
  - sample_cnt=0, bit_cnt=0, RControl=0, frame_done=0.
  - Outputs are held there while rst=0.
  - Deasserting reset mid-frame restarts counting from sample 0, bit 0.
- enable=0 at a clock edge: synchronously clears sample_cnt and bit_cnt to 0 and drives RControl=0, frame_done=0.
  - A frame aborted by dropping enable restarts from 0 when enable rises again.
- enable=1 at a clock edge:
  - sample_cnt increments by 1.
  - At SAMPLES_PER_BIT-1, sample_cnt wraps to 0.
  - On that wrap edge, bit_cnt increments, wrapping from BITS_PER_FRAME-1 to 0.
- RControl is registered. It is set to 1 on an edge where enable=1 and sample_cnt==SAMPLE_POINT, and is 0 after every other edge.
  - Consequence: RControl is high for exactly one clock, while sample_cnt==SAMPLE_POINT+1.
  - First strobe appears after the (SAMPLE_POINT+1)th enabled edge; subsequent strobes follow every SAMPLES_PER_BIT enabled edges.
- frame_done is registered. It is set on the same edge as RControl when bit_cnt==BITS_PER_FRAME-1; otherwise 0.
- Continuous enable: counting continues across frames with no gap (bit_cnt wraps to 0).
- Simultaneous events: reset dominates enable. With enable=0 the clear takes effect regardless of count state.
- No X propagation: all outputs are driven from reset onward.

Test Plan:
- Reset: hold rst=0 for 2 cycles with enable=1 -> RControl=0, frame_done=0, sample_cnt=0, bit_cnt=0; assert rst=0 between clock edges and check outputs clear immediately (asynchronous).
- First strobe: release rst, set enable=1 -> RControl low after edges 1–7, high for one cycle after edge 8 (sample_cnt=8), low after edge 9.
- Periodicity: keep enable=1 -> RControl pulses after edges 8, 24, 40, ...; bit_cnt goes 0→1 after edge 16 and 1→2 after edge 32.
- Frame end: continuous enable -> 10th RControl pulse (after edge 152) coincides with frame_done=1; bit_cnt wraps to 0 after edge 160; next pulse after edge 168 without frame_done.
- Abort: drop enable for 1 cycle when sample_cnt=5, bit_cnt=3 -> both counters 0, no strobe; on re-enable, first RControl after 8 further edges.
- Reset mid-frame: pulse rst=0 while RControl=1 -> RControl drops immediately; counting restarts at 0 after release.
